// File: rtl/uc_pkg.sv
// Shared types for the multi-cycle control unit: FSM states, opcodes,
// jump condition codes and the fixed-width part of the control word.
package uc_pkg;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } uc_estado_t;

  localparam int OP_LOAD_1  = 0;
  localparam int OP_LOAD_2  = 1;
  localparam int OP_STORE_1 = 2;
  localparam int OP_STORE_2 = 3;
  localparam int OP_MOVE    = 4;
  localparam int OP_MATH    = 5;
  localparam int OP_JUMP    = 6;
  localparam int OP_NOP     = 7;

  // Codes 2 and above test one flag each: 2k+2 taken on flag[k]==1, 2k+3 on flag[k]==0.
  localparam logic [2:0] COND_INCOND = 3'd0;
  localparam logic [2:0] COND_ENLACE = 3'd1;

  // Register-address fields travel beside this struct because their width
  // is a module parameter.
  typedef struct packed {
    logic       salto;
    logic [1:0] sel;
    logic [1:0] rw;
    logic [2:0] ctl;
    logic [2:0] inst;
    logic       hab;
  } uc_ctrl_t;

  function automatic logic es_memoria(input logic [31:0] opc);
    return opc <= 32'(OP_STORE_2);
  endfunction

endpackage

// File: rtl/uc_decodificador.sv
// Combinational decoder: latched opcode, operands and flags -> control word,
// plus whether the instruction touches memory and whether it writes back.
module uc_decodificador
  import uc_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int FLAG_W     = 3,
  parameter int OPC_W      = 3
) (
  input  logic [OPC_W-1:0]        opcode,
  input  logic [2*REG_ADDR_W-1:0] operandos,
  input  logic [FLAG_W-1:0]       banderas,
  output uc_ctrl_t                ctrl,
  output logic [REG_ADDR_W-1:0]   rx,
  output logic [REG_ADDR_W-1:0]   ry,
  output logic [REG_ADDR_W-1:0]   wsel,
  output logic [REG_ADDR_W-1:0]   rsel,
  output logic                    escribe,
  output logic                    memoria
);

  logic [REG_ADDR_W-1:0] op_a;
  logic [REG_ADDR_W-1:0] op_b;
  logic [2:0]            cond;
  logic                  tomado;

  assign op_a    = operandos[2*REG_ADDR_W-1:REG_ADDR_W];
  assign op_b    = operandos[REG_ADDR_W-1:0];
  assign cond    = op_b[2:0];
  assign memoria = es_memoria(32'(opcode));

  // Flag index k = cond/2 - 1; indices beyond FLAG_W leave the jump untaken.
  always_comb begin
    tomado = 1'b0;
    if (cond <= COND_ENLACE) begin
      tomado = 1'b1;
    end else begin
      for (int i = 0; i < FLAG_W; i++) begin
        if (int'(cond[2:1]) - 1 == i) tomado = cond[0] ? ~banderas[i] : banderas[i];
      end
    end
  end

  always_comb begin
    ctrl    = '0;
    rx      = '0;
    ry      = '0;
    wsel    = '0;
    rsel    = '0;
    escribe = 1'b0;
    case (opcode)
      OPC_W'(OP_LOAD_1): begin
        ctrl.sel = 2'b01;
        ctrl.rw  = 2'b01;
        wsel     = op_a;
        escribe  = 1'b1;
      end
      OPC_W'(OP_LOAD_2): begin
        ctrl.sel = 2'b10;
        ctrl.rw  = 2'b11;
        ry       = op_b;
        wsel     = op_a;
        ctrl.ctl = 3'b100;
        escribe  = 1'b1;
      end
      OPC_W'(OP_STORE_1): begin
        rx       = op_b;
        ctrl.ctl = 3'b111;
      end
      OPC_W'(OP_STORE_2): begin
        rx       = op_a;
        ry       = op_b;
        ctrl.ctl = 3'b110;
      end
      OPC_W'(OP_MOVE): begin
        wsel    = op_a;
        rsel    = op_b;
        escribe = 1'b1;
      end
      OPC_W'(OP_MATH): begin
        ctrl.rw   = 2'b11;
        rx        = op_a;
        ctrl.inst = op_b[2:0];
        ctrl.hab  = 1'b1;
        escribe   = 1'b1;
      end
      OPC_W'(OP_JUMP): begin
        if (tomado) begin
          ctrl.salto = 1'b1;
          rx         = op_a;
          if (cond != COND_INCOND) begin
            ctrl.sel = 2'b11;
            ctrl.rw  = 2'b11;
            wsel     = '1;
            escribe  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/unidad_de_control_multiciclo.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE/WRITEBACK with a memory stall.
// Optional UC_CONTADOR_RETIRADAS_EN adds a 32-bit retired-instruction counter.
module unidad_de_control_multiciclo
  import uc_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int FLAG_W     = 3,
  parameter int OPC_W      = 3
) (
  input  logic                    i_Timming,
  input  logic                    i_Rst,
  input  logic                    i_Instr_valid,
  output logic                    o_Instr_ready,
  input  logic [OPC_W-1:0]        i_Operation_code,
  input  logic [2*REG_ADDR_W-1:0] i_Operandos,
  input  logic [FLAG_W-1:0]       i_Bandera,
  input  logic                    i_Mem_ready,
  output logic                    o_Mem_req,
  output logic                    o_Wr_en,
  output logic                    o_Senal_de_salto,
  output logic [1:0]              o_Selector_de_entrada_a_registros,
  output logic [1:0]              o_Lectura_escritura,
  output logic [REG_ADDR_W-1:0]   o_Control_RX,
  output logic [REG_ADDR_W-1:0]   o_Control_RY,
  output logic [REG_ADDR_W-1:0]   o_Seleccion_registro_escritura,
  output logic [REG_ADDR_W-1:0]   o_Seleccion_registro_lectura,
  output logic [2:0]              o_Senal_de_control,
  output logic [2:0]              o_Inst_decodificada,
  output logic                    o_Hab,
  output logic [1:0]              o_Estado
`ifdef UC_CONTADOR_RETIRADAS_EN
  ,
  output logic [31:0]             o_Instr_retiradas
`endif
);

  // Handshake: an instruction transfers on a rising edge where
  // i_Instr_valid && o_Instr_ready; o_Instr_ready is high only in FETCH.

  uc_estado_t              estado;
  logic [OPC_W-1:0]        opc_q;
  logic [2*REG_ADDR_W-1:0] opr_q;
  logic [FLAG_W-1:0]       flg_q;
  uc_ctrl_t                ctrl_d, ctrl_q;
  logic [REG_ADDR_W-1:0]   rx_d, ry_d, wsel_d, rsel_d;
  logic [REG_ADDR_W-1:0]   rx_q, ry_q, wsel_q, rsel_q;
  logic                    esc_d, mem_d;
  logic                    mem_req_q, wr_en_q;
  logic                    retira;

  uc_decodificador #(
    .REG_ADDR_W(REG_ADDR_W),
    .FLAG_W    (FLAG_W),
    .OPC_W     (OPC_W)
  ) u_dec (
    .opcode   (opc_q),
    .operandos(opr_q),
    .banderas (flg_q),
    .ctrl     (ctrl_d),
    .rx       (rx_d),
    .ry       (ry_d),
    .wsel     (wsel_d),
    .rsel     (rsel_d),
    .escribe  (esc_d),
    .memoria  (mem_d)
  );

  assign retira = (estado == WRITEBACK) ||
                  ((estado == EXECUTE) && (!mem_req_q || i_Mem_ready) && !esc_d);

  always_ff @(posedge i_Timming) begin
    if (i_Rst) begin
      estado    <= FETCH;
      opc_q     <= '0;
      opr_q     <= '0;
      flg_q     <= '0;
      ctrl_q    <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      wsel_q    <= '0;
      rsel_q    <= '0;
      mem_req_q <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      case (estado)
        FETCH: begin
          if (i_Instr_valid) begin
            opc_q  <= i_Operation_code;
            opr_q  <= i_Operandos;
            flg_q  <= i_Bandera;
            estado <= DECODE;
          end
        end
        DECODE: begin
          ctrl_q    <= ctrl_d;
          rx_q      <= rx_d;
          ry_q      <= ry_d;
          wsel_q    <= wsel_d;
          rsel_q    <= rsel_d;
          mem_req_q <= mem_d;
          estado    <= EXECUTE;
        end
        EXECUTE: begin
          // Memory operations stall here with the control word frozen.
          if (!mem_req_q || i_Mem_ready) begin
            mem_req_q <= 1'b0;
            if (esc_d) begin
              wr_en_q <= 1'b1;
              estado  <= WRITEBACK;
            end else begin
              ctrl_q <= '0;
              rx_q   <= '0;
              ry_q   <= '0;
              wsel_q <= '0;
              rsel_q <= '0;
              estado <= FETCH;
            end
          end
        end
        WRITEBACK: begin
          wr_en_q <= 1'b0;
          ctrl_q  <= '0;
          rx_q    <= '0;
          ry_q    <= '0;
          wsel_q  <= '0;
          rsel_q  <= '0;
          estado  <= FETCH;
        end
        default: estado <= FETCH;
      endcase
    end
  end

`ifdef UC_CONTADOR_RETIRADAS_EN
  logic [31:0] retiradas_q;

  always_ff @(posedge i_Timming) begin
    if (i_Rst) retiradas_q <= '0;
    else if (retira) retiradas_q <= retiradas_q + 32'd1;
  end

  assign o_Instr_retiradas = retiradas_q;
`else
  logic retira_sin_uso;
  assign retira_sin_uso = retira;
`endif

  assign o_Instr_ready                     = (estado == FETCH);
  assign o_Estado                          = estado;
  assign o_Mem_req                         = mem_req_q;
  assign o_Wr_en                           = wr_en_q;
  assign o_Senal_de_salto                  = ctrl_q.salto;
  assign o_Selector_de_entrada_a_registros = ctrl_q.sel;
  assign o_Lectura_escritura               = ctrl_q.rw;
  assign o_Control_RX                      = rx_q;
  assign o_Control_RY                      = ry_q;
  assign o_Seleccion_registro_escritura    = wsel_q;
  assign o_Seleccion_registro_lectura      = rsel_q;
  assign o_Senal_de_control                = ctrl_q.ctl;
  assign o_Inst_decodificada               = ctrl_q.inst;
  assign o_Hab                             = ctrl_q.hab;

endmodule

// File: tb/tb_unidad_de_control_multiciclo.sv
// Directed bench for unidad_de_control_multiciclo; checks the retired counter
// too when UC_CONTADOR_RETIRADAS_EN is defined.
module tb_unidad_de_control_multiciclo;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       ready;
  logic [2:0] opc;
  logic [5:0] opr;
  logic [2:0] flg;
  logic       mem_ready;
  logic       mem_req;
  logic       wr_en;
  logic       salto;
  logic [1:0] sel;
  logic [1:0] rw;
  logic [2:0] rx, ry, wsel, rsel;
  logic [2:0] ctl;
  logic [2:0] inst;
  logic       hab;
  logic [1:0] estado;
  logic [23:0] word_obs;

  int n_asserts = 0;
  int n_fail    = 0;
  int acc;
`ifdef UC_CONTADOR_RETIRADAS_EN
  logic [31:0] retiradas;
`endif

  // clock / reset
  always #5 clk = ~clk;

  unidad_de_control_multiciclo #(
    .REG_ADDR_W(3),
    .FLAG_W    (3),
    .OPC_W     (3)
  ) dut (
    .i_Timming                        (clk),
    .i_Rst                            (rst),
    .i_Instr_valid                    (valid),
    .o_Instr_ready                    (ready),
    .i_Operation_code                 (opc),
    .i_Operandos                      (opr),
    .i_Bandera                        (flg),
    .i_Mem_ready                      (mem_ready),
    .o_Mem_req                        (mem_req),
    .o_Wr_en                          (wr_en),
    .o_Senal_de_salto                 (salto),
    .o_Selector_de_entrada_a_registros(sel),
    .o_Lectura_escritura              (rw),
    .o_Control_RX                     (rx),
    .o_Control_RY                     (ry),
    .o_Seleccion_registro_escritura   (wsel),
    .o_Seleccion_registro_lectura     (rsel),
    .o_Senal_de_control               (ctl),
    .o_Inst_decodificada              (inst),
    .o_Hab                            (hab),
    .o_Estado                         (estado)
`ifdef UC_CONTADOR_RETIRADAS_EN
    ,
    .o_Instr_retiradas                (retiradas)
`endif
  );

  assign word_obs = {salto, sel, rw, rx, ry, wsel, rsel, ctl, inst, hab};

  function automatic logic [23:0] cw(input logic s, input logic [1:0] e_sel, input logic [1:0] e_rw,
                                     input logic [2:0] e_rx, input logic [2:0] e_ry,
                                     input logic [2:0] e_wsel, input logic [2:0] e_rsel,
                                     input logic [2:0] e_ctl, input logic [2:0] e_inst, input logic e_hab);
    return {s, e_sel, e_rw, e_rx, e_ry, e_wsel, e_rsel, e_ctl, e_inst, e_hab};
  endfunction

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] t_opc, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] t_flg);
    valid = 1'b1;
    opc   = t_opc;
    opr   = {a, b};
    flg   = t_flg;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_estado"}, 32'(estado), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_word"}, 32'(word_obs), 32'd0);
    chk({tag, "_memreq"}, 32'(mem_req), 32'd0);
    chk({tag, "_wren"}, 32'(wr_en), 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; opc = '0; opr = '0; flg = '0; mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset");
`ifdef UC_CONTADOR_RETIRADAS_EN
    chk("ret_reset", retiradas, 32'd0);
`endif

    // STORE_2 A=2 B=5, reset while stalled
    send(3'd3, 3'd2, 3'd5, 3'd0);
    tick();
    valid = 1'b0;
    chk("st2_decode", 32'(estado), 32'd1);
    tick();
    chk("st2_exec", 32'(estado), 32'd2);
    chk("st2_memreq", 32'(mem_req), 32'd1);
    chk("st2_word", 32'(word_obs), 32'(cw(1'b0, 2'b00, 2'b00, 3'd2, 3'd5, 3'd0, 3'd0, 3'b110, 3'd0, 1'b0)));
    tick();
    chk("st2_stall", 32'(estado), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst_stall");

    // LOAD_2 A=5 B=2, memory ready low for 3 cycles
    send(3'd1, 3'd5, 3'd2, 3'd0);
    tick();
    valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("ld2_exec", 32'(estado), 32'd2);
      chk("ld2_memreq", 32'(mem_req), 32'd1);
      chk("ld2_wren", 32'(wr_en), 32'd0);
      chk("ld2_word", 32'(word_obs), 32'(cw(1'b0, 2'b10, 2'b11, 3'd0, 3'd2, 3'd5, 3'd0, 3'b100, 3'd0, 1'b0)));
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    chk("ld2_wb", 32'(estado), 32'd3);
    chk("ld2_wren_wb", 32'(wr_en), 32'd1);
    chk("ld2_memreq_wb", 32'(mem_req), 32'd0);
    chk("ld2_word_wb", 32'(word_obs), 32'(cw(1'b0, 2'b10, 2'b11, 3'd0, 3'd2, 3'd5, 3'd0, 3'b100, 3'd0, 1'b0)));
    mem_ready = 1'b0;
    tick();
    chk_idle("ld2_done");

    // STORE_1 A=1 B=4 with memory already ready: no writeback
    mem_ready = 1'b1;
    send(3'd2, 3'd1, 3'd4, 3'd0);
    tick();
    valid = 1'b0;
    tick();
    chk("st1_exec", 32'(estado), 32'd2);
    chk("st1_memreq", 32'(mem_req), 32'd1);
    chk("st1_word", 32'(word_obs), 32'(cw(1'b0, 2'b00, 2'b00, 3'd4, 3'd0, 3'd0, 3'd0, 3'b111, 3'd0, 1'b0)));
    tick();
    chk_idle("st1_done");

    // MATH A=3 B=6, stray memory ready must be ignored
    send(3'd5, 3'd3, 3'd6, 3'd0);
    tick();
    valid = 1'b0;
    chk("math_decode", 32'(estado), 32'd1);
    chk("math_ready_dec", 32'(ready), 32'd0);
    tick();
    chk("math_exec", 32'(estado), 32'd2);
    chk("math_memreq", 32'(mem_req), 32'd0);
    chk("math_wren_ex", 32'(wr_en), 32'd0);
    chk("math_word", 32'(word_obs), 32'(cw(1'b0, 2'b00, 2'b11, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 1'b1)));
    tick();
    chk("math_wb", 32'(estado), 32'd3);
    chk("math_wren", 32'(wr_en), 32'd1);
    mem_ready = 1'b0;
    tick();
    chk_idle("math_done");

    // JUMP cond=3 with flag0=1: not taken, later flag change ignored
    send(3'd6, 3'd4, 3'd3, 3'b001);
    tick();
    valid = 1'b0;
    flg = 3'b000;
    tick();
    chk("jnt_exec", 32'(estado), 32'd2);
    chk("jnt_word", 32'(word_obs), 32'd0);
    tick();
    chk_idle("jnt_done");

    // JUMP cond=3 with flag0=0: taken with link
    send(3'd6, 3'd4, 3'd3, 3'b000);
    tick();
    valid = 1'b0;
    flg = 3'b001;
    tick();
    chk("jt_exec", 32'(estado), 32'd2);
    chk("jt_word", 32'(word_obs), 32'(cw(1'b1, 2'b11, 2'b11, 3'd4, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 1'b0)));
    tick();
    chk("jt_wb", 32'(estado), 32'd3);
    chk("jt_wren", 32'(wr_en), 32'd1);
    tick();
    chk_idle("jt_done");

    // NOP: three cycles, nothing asserted
    send(3'd7, 3'd5, 3'd5, 3'b111);
    tick();
    valid = 1'b0;
    chk("nop_decode", 32'(estado), 32'd1);
    chk("nop_memreq_d", 32'(mem_req), 32'd0);
    tick();
    chk("nop_exec", 32'(estado), 32'd2);
    chk("nop_word", 32'(word_obs), 32'd0);
    chk("nop_memreq", 32'(mem_req), 32'd0);
    chk("nop_wren", 32'(wr_en), 32'd0);
    tick();
    chk_idle("nop_done");
`ifdef UC_CONTADOR_RETIRADAS_EN
    chk("ret_before_moves", retiradas, 32'd6);
`endif

    // Four back-to-back MOVEs A=6 B=1 with valid held high
    send(3'd4, 3'd6, 3'd1, 3'd0);
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      chk("mv_estado", 32'(estado), 32'(i % 4));
      chk("mv_ready", 32'(ready), 32'(i % 4 == 0));
      if (ready && valid) acc++;
      if (i % 4 == 2) chk("mv_word", 32'(word_obs), 32'(cw(1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 3'd6, 3'd1, 3'd0, 3'd0, 1'b0)));
      if (i % 4 == 3) chk("mv_wren", 32'(wr_en), 32'd1);
      if (i == 13) valid = 1'b0;
      tick();
    end
    chk("mv_accepted", 32'(acc), 32'd4);
    chk_idle("mv_done");
`ifdef UC_CONTADOR_RETIRADAS_EN
    chk("ret_after_moves", retiradas, 32'd10);
`endif
    tick();
    chk("idle_hold", 32'(estado), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/unidad_de_control_multiciclo.md
Name: unidad_de_control_multiciclo

Overview:
Parametrised multi-cycle successor to the single-cycle control unit. Accepts instructions through a valid/ready handshake and walks each one through a FETCH/DECODE/EXECUTE/WRITEBACK state machine. Memory instructions stall in EXECUTE until memory acknowledges, and register writes are gated by an explicit one-cycle write-enable pulse. Sits between the instruction register/PC logic and the register file, ALU and data memory.

Parameters:
REG_ADDR_W, 3, register-address width; operand field is 2*REG_ADDR_W bits (A = upper half, B = lower half)
FLAG_W, 3, number of ALU flags tested by conditional jumps
OPC_W, 3, opcode width; only codes 0-7 are defined, all others execute as NOP

Ports:
i_Timming  in  1  clock, rising edge
i_Rst  in  1  synchronous active-high reset
i_Instr_valid  in  1  instruction word present
o_Instr_ready  out  1  unit in FETCH and able to accept an instruction
i_Operation_code  in  OPC_W  opcode
i_Operandos  in  2*REG_ADDR_W  operand field
i_Bandera  in  FLAG_W  ALU flags, sampled at handshake
i_Mem_ready  in  1  data-memory acknowledge
o_Mem_req  out  1  memory access in progress
o_Wr_en  out  1  register-file write strobe
o_Senal_de_salto  out  1  PC load
o_Selector_de_entrada_a_registros  out  2  register-file input mux select
o_Lectura_escritura  out  2  read/write mode
o_Control_RX, o_Control_RY  out  REG_ADDR_W each  ALU/memory source registers
o_Seleccion_registro_escritura, o_Seleccion_registro_lectura  out  REG_ADDR_W each  write/read register address
o_Senal_de_control  out  3  memory control code
o_Inst_decodificada  out  3  ALU operation
o_Hab  out  1  ALU enable
o_Estado  out  2  current state: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3

Behaviour:
- Clocking/reset: single clock i_Timming; i_Rst is synchronous and active-high. On reset: state=FETCH and every control output=0. o_Instr_ready is combinational (state==FETCH), so it reads 1 immediately after reset.
- FETCH: o_Instr_ready=1 and all control outputs are 0. On a valid&&ready edge, latch opcode, operands and flags, then go to DECODE.
- DECODE: builds the registered control word; next state is EXECUTE.
- Control words are listed as fields that differ from 0; every unlisted field is 0.
  - LOAD_1 (0): sel=01, rw=01, wsel=A.
  - LOAD_2 (1): sel=10, rw=11, RY=B, wsel=A, ctl=100.
  - STORE_1 (2): RX=B, ctl=111.
  - STORE_2 (3): RX=A, RY=B, ctl=110.
  - MOVE (4): wsel=A, rsel=B.
  - MATH (5): rw=11, RX=A, inst=B[2:0], hab=1.
  - JUMP (6): cond=B[2:0].
    - cond 0: unconditional jump, no link; salto=1, RX=A.
    - cond 1: jump with link; salto=1, RX=A, sel=11, rw=11, wsel=all-ones (link register).
    - cond 2k+2 / 2k+3: same as cond 1, but taken only if flag[k]==1 / flag[k]==0.
    - k>=FLAG_W, or condition false: all-zero control word.
  - NOP (7 and undefined opcodes): all-zero control word.
- EXECUTE: control word is driven on the outputs.
  - Opcodes 0-3 assert o_Mem_req and hold in EXECUTE until i_Mem_ready=1; the control word stays stable while stalled.
  - Other opcodes stay 1 cycle.
- EXECUTE exit:
  - To WRITEBACK for LOAD_1, LOAD_2, MOVE, MATH and taken link jumps.
  - Otherwise to FETCH.
- WRITEBACK: o_Wr_en=1 for exactly one cycle with the control word still held; then FETCH clears all outputs.
- Latency: handshake edge to control word visible = 2 edges. A non-memory instruction without writeback completes in 3 cycles including FETCH; with writeback, 4 cycles. Memory instructions take 3 + wait cycles, plus 1 more for loads.
- Boundary conditions:
  - i_Rst has priority over everything; reset during an EXECUTE stall drops the instruction and de-asserts o_Mem_req the next cycle.
  - i_Instr_valid is ignored outside FETCH.
  - i_Mem_ready outside a memory EXECUTE is ignored.
  - Flags are sampled only at handshake; later changes have no effect.

Optional Feature:
UC_CONTADOR_RETIRADAS_EN
- Defined: adds output o_Instr_retiradas (32 bits) counting instructions that leave EXECUTE/WRITEBACK back to FETCH, NOPs and untaken jumps included. The counter wraps from 2^32-1 to 0 and is cleared by i_Rst.
- Undefined: the port and the counter are absent.

Decomposition:
- Package uc_pkg:
  - state enum (FETCH/DECODE/EXECUTE/WRITEBACK);
  - opcode localparams (LOAD_1..NOP);
  - jump condition codes;
  - control-word struct (salto, sel, rw, RX, RY, wsel, rsel, ctl, inst, hab).
- One natural sub-module, uc_decodificador: purely combinational; opcode + operands + flags -> control word. The top level keeps the FSM, the registers and the handshake.

Test Plan:
- Reset: assert i_Rst mid-stall on STORE_2 -> next cycle o_Estado=0, o_Mem_req=0, all control outputs 0, o_Instr_ready=1.
- LOAD_2, operands A=5 B=2: i_Mem_ready held low for 3 cycles.
  - EXECUTE lasts 4 cycles with sel=10, RY=2, wsel=5, ctl=100.
  - Then o_Wr_en pulses for 1 cycle, then back to FETCH.
- MATH A=3 B=6 -> 2 edges after handshake: RX=3, inst=6, hab=1, rw=11; o_Wr_en pulse on the following cycle.
- JUMP cond=3 (taken if flag0==0), flags=3'b001 -> not taken: all-zero control word, no o_Wr_en. Repeat with flags=3'b000 -> salto=1, wsel=7, o_Wr_en pulse.
- Back-to-back: i_Instr_valid held high for 4 MOVEs -> one accepted every 4 cycles (handshake only in FETCH); with UC_CONTADOR_RETIRADAS_EN, o_Instr_retiradas=4.
- Opcode 7 -> 3-cycle NOP, all outputs 0, o_Mem_req never asserted.
